// File: rtl/fetch_pkg.sv
// Shared types and constants for the BittyPro instruction fetch stage.
package fetch_pkg;

   localparam int INSTR_W = 16;
   localparam logic [INSTR_W-1:0] DEFAULT_HALT_WORD = 16'hFFFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_ISSUE,
      ST_WAIT,
      ST_HALT
   } fetch_state_t;

endpackage

// File: rtl/instr_mem.sv
// Single-port 2^ADDR_W x 16 instruction store, synchronous write, registered read.
// Read data appears one cycle after the address; no backpressure, one access per cycle.
module instr_mem
   import fetch_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic               clk,
   input  logic               we,
   input  logic [ADDR_W-1:0]  addr,
   input  logic [INSTR_W-1:0] wr_dat,
   output logic [INSTR_W-1:0] rd_dat
);

   logic [INSTR_W-1:0] mem [2**ADDR_W];

   // Contents deliberately survive reset so a program stays loaded across restarts.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wr_dat;
      end
      rd_dat <= mem[addr];
   end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: loadable program memory plus PC, issuing one instruction per done pulse.
// Three edges from start/done to a valid instruction; the core stalls fetch by withholding done.
module instr_fetch
   import fetch_pkg::*;
#(
   parameter int                 ADDR_W    = 8,
   parameter logic [INSTR_W-1:0] HALT_WORD = DEFAULT_HALT_WORD
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               load_en,
   input  logic [ADDR_W-1:0]  load_addr,
   input  logic [INSTR_W-1:0] load_data,
   input  logic               done,
   input  logic               branch_en,
   input  logic [ADDR_W-1:0]  branch_addr,
   output logic [INSTR_W-1:0] instruction,
   output logic               instr_valid,
   output logic [ADDR_W-1:0]  pc,
   output logic               running,
   output logic               halted
);

   fetch_state_t       state;
   fetch_state_t       state_nxt;
   logic [ADDR_W-1:0]  pc_nxt;
   logic [INSTR_W-1:0] instr_nxt;
   logic [INSTR_W-1:0] rd_dat;
   logic [ADDR_W-1:0]  mem_addr;
   logic               load_ok;
   logic               mem_we;
   logic               rd_is_halt;

   // Loads only land while fetch is parked, so the single port never sees a read/write clash.
   assign load_ok    = (state == ST_IDLE) || (state == ST_HALT);
   assign mem_we     = load_en && load_ok;
   assign mem_addr   = mem_we ? load_addr : pc;
   assign rd_is_halt = (rd_dat == HALT_WORD);

   instr_mem #(
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk    (clk),
      .we     (mem_we),
      .addr   (mem_addr),
      .wr_dat (load_data),
      .rd_dat (rd_dat)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_HALT: if (start) state_nxt = ST_FETCH;
         ST_FETCH:         state_nxt = ST_ISSUE;
         ST_ISSUE:         state_nxt = rd_is_halt ? ST_HALT : ST_WAIT;
         ST_WAIT:          if (done) state_nxt = ST_FETCH;
         default:          state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      instr_valid = 1'b0;
      running     = 1'b0;
      halted      = 1'b0;
      case (state)
         ST_FETCH, ST_ISSUE: running = 1'b1;
         ST_WAIT: begin
            running     = 1'b1;
            instr_valid = 1'b1;
         end
         ST_HALT: halted = 1'b1;
         default: ;
      endcase
   end

   // A halt word leaves both PC and the instruction register untouched.
   always_comb begin
      pc_nxt    = pc;
      instr_nxt = instruction;
      case (state)
         ST_IDLE, ST_HALT: if (start) pc_nxt = '0;
         ST_ISSUE:         if (!rd_is_halt) instr_nxt = rd_dat;
         ST_WAIT:          if (done) pc_nxt = branch_en ? branch_addr : pc + ADDR_W'(1);
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc          <= '0;
         instruction <= '0;
      end else begin
         pc          <= pc_nxt;
         instruction <= instr_nxt;
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomised scoreboard bench for instr_fetch against a memory/PC reference model.
module tb_instr_fetch;

   localparam int          ADDR_W = 8;
   localparam int          DEPTH  = 256;
   localparam logic [15:0] HW     = 16'hFFFF;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic              load_en = 1'b0;
   logic [ADDR_W-1:0] load_addr = '0;
   logic [15:0]       load_data = '0;
   logic              done = 1'b0;
   logic              branch_en = 1'b0;
   logic [ADDR_W-1:0] branch_addr = '0;
   logic [15:0]       instruction;
   logic              instr_valid;
   logic [ADDR_W-1:0] pc;
   logic              running;
   logic              halted;

   instr_fetch #(
      .ADDR_W    (ADDR_W),
      .HALT_WORD (HW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .load_en     (load_en),
      .load_addr   (load_addr),
      .load_data   (load_data),
      .done        (done),
      .branch_en   (branch_en),
      .branch_addr (branch_addr),
      .instruction (instruction),
      .instr_valid (instr_valid),
      .pc          (pc),
      .running     (running),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic              halt;
      logic [ADDR_W-1:0] pc;
      logic [15:0]       instr;
   } exp_t;

   exp_t              sb[$];
   logic [15:0]       m_mem [DEPTH];
   logic [ADDR_W-1:0] m_pc = '0;
   logic [15:0]       m_instr = '0;
   logic              m_running = 1'b0;
   int                n_chk = 0;
   int                n_fail = 0;
   logic              prev_valid = 1'b0;
   logic              prev_halted = 1'b0;
   logic [15:0]       held_instr = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference: what the next issue from address a must look like.
   function automatic logic predict(input logic [ADDR_W-1:0] a);
      exp_t e;
      e.pc   = a;
      e.halt = (m_mem[a] == HW);
      if (!e.halt) m_instr = m_mem[a];
      e.instr   = m_instr;
      m_pc      = a;
      m_running = !e.halt;
      sb.push_back(e);
      return e.halt;
   endfunction

   task automatic chk_reset(input string nm);
      chk({nm, "_valid"}, 32'(instr_valid), 0);
      chk({nm, "_running"}, 32'(running), 0);
      chk({nm, "_halted"}, 32'(halted), 0);
      chk({nm, "_pc"}, 32'(pc), 0);
      chk({nm, "_instr"}, 32'(instruction), 0);
   endtask

   task automatic wait_sb(input string nm);
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      chk({nm, "_sb_drained"}, 32'(sb.size()), 0);
      sb.delete();
   endtask

   // Inputs were driven just after a falling edge; the result must appear on the third rising edge.
   task automatic timed(input string nm, input logic exp_halt, input logic hold_done);
      for (int n = 1; n <= 3; n++) begin
         @(negedge clk);
         if (n == 1) begin
            start   = 1'b0;
            load_en = 1'b0;
            if (hold_done) begin
               branch_en   = 1'b1;
               branch_addr = m_pc ^ 8'hA5;
            end else begin
               done      = 1'b0;
               branch_en = 1'b0;
            end
            chk({nm, "_running"}, 32'(running), 1);
         end
         if (n < 3) chk({nm, "_busy"}, {30'd0, instr_valid, halted}, 0);
         else       chk({nm, "_ready"}, {30'd0, instr_valid, halted}, exp_halt ? 1 : 2);
      end
      done      = 1'b0;
      branch_en = 1'b0;
      wait_sb(nm);
   endtask

   task automatic load(input logic [ADDR_W-1:0] a, input logic [15:0] d);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      if (!m_running) m_mem[a] = d;
      @(negedge clk);
      load_en = 1'b0;
   endtask

   task automatic do_start(input string nm);
      logic h;
      start = 1'b1;
      h = predict('0);
      timed(nm, h, 1'b0);
   endtask

   task automatic load_start(input string nm, input logic [ADDR_W-1:0] a, input logic [15:0] d);
      logic h;
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      m_mem[a]  = d;
      start     = 1'b1;
      h = predict('0);
      timed(nm, h, 1'b0);
   endtask

   task automatic pulse_done(input string nm, input logic br, input logic [ADDR_W-1:0] ba,
                             input logic hold);
      logic h;
      logic [ADDR_W-1:0] nxt;
      nxt = br ? ba : ADDR_W'((int'(m_pc) + 1) % DEPTH);
      done        = 1'b1;
      branch_en   = br;
      branch_addr = ba;
      h = predict(nxt);
      timed(nm, h, hold);
   endtask

   // start and load_en during WAIT must change nothing.
   task automatic poke_wait();
      start     = 1'b1;
      load_en   = 1'b1;
      load_addr = '0;
      load_data = 16'hDEAD;
      @(negedge clk);
      start   = 1'b0;
      load_en = 1'b0;
      chk("poke_pc", 32'(pc), 32'(m_pc));
      chk("poke_valid_running", {30'd0, instr_valid, running}, 3);
      chk("poke_instr", 32'(instruction), 32'(m_instr));
   endtask

   task automatic reset_mid(input string nm);
      @(posedge clk);
      #2 reset = 1'b1;
      #1 chk_reset(nm);
      @(negedge clk);
      @(negedge clk);
      reset     = 1'b0;
      m_pc      = '0;
      m_instr   = '0;
      m_running = 1'b0;
      sb.delete();
   endtask

   // Monitor: each new WAIT or HALT entry consumes one scoreboard entry.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if ((instr_valid && !prev_valid) || (halted && !prev_halted)) begin
               if (sb.size() == 0) begin
                  chk("unexpected_output", {30'd0, instr_valid, halted}, 0);
               end else begin
                  e = sb.pop_front();
                  chk("kind_halt", 32'(halted), 32'(e.halt));
                  chk("pc", 32'(pc), 32'(e.pc));
                  chk("instruction", 32'(instruction), 32'(e.instr));
                  held_instr = e.instr;
               end
            end else if (instr_valid && prev_valid) begin
               chk("instr_stable", 32'(instruction), 32'(held_instr));
            end
         end
         prev_valid  = instr_valid;
         prev_halted = halted;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1, "watchdog expired");
   end

   initial begin
      #2 reset = 1'b1;
      #1 chk_reset("por");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      for (int a = 0; a < DEPTH; a++)
         load(ADDR_W'(a), ($urandom_range(0, 7) == 0) ? HW : 16'($urandom));

      load(8'd0, 16'h1234);
      load(8'd1, 16'h0042);
      load(8'd2, HW);
      do_start("start");
      pulse_done("seq", 1'b0, '0, 1'b0);
      pulse_done("seq_halt", 1'b0, '0, 1'b0);

      load(8'd0, 16'h0001);
      load(8'd9, HW);
      do_start("br_start");
      pulse_done("branch_halt", 1'b1, 8'd9, 1'b0);

      load(8'd255, 16'h0007);
      do_start("wrap_start");
      pulse_done("to_255", 1'b1, 8'd255, 1'b0);
      pulse_done("wrap", 1'b0, '0, 1'b0);
      poke_wait();
      pulse_done("ignored_done", 1'b1, 8'd0, 1'b1);

      reset_mid("rst_a");
      load(8'd0, 16'h1234);
      load(8'd1, HW);
      do_start("pre_rst");
      reset_mid("rst_wait");
      do_start("post_rst");
      pulse_done("halt_1", 1'b0, '0, 1'b0);
      load_start("ld_start", 8'd0, 16'hABCD);

      for (int i = 0; i < 80; i++) begin
         if (!m_running) begin
            if ($urandom_range(0, 1) == 1)
               load_start("rnd_ldst", ADDR_W'($urandom),
                          ($urandom_range(0, 3) == 0) ? HW : 16'($urandom));
            else
               do_start("rnd_start");
         end else begin
            if ($urandom_range(0, 7) == 0) poke_wait();
            pulse_done("rnd_done", $urandom_range(0, 3) == 0, ADDR_W'($urandom),
                       $urandom_range(0, 4) == 0);
         end
      end

      repeat (4) @(negedge clk);
      chk("final_sb_empty", 32'(sb.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
